// File: rtl/cache_nway_ctrl.sv
// cache_nway_ctrl
//   N-way set-associative, one-word-per-line cache controller between the
//   core load/store port and a request/ack backing store. It handles one
//   request at a time (IDLE / MISS / WRITE). Replacement is round-robin per
//   set. Writes go through to the backing store and update the line on a hit.
//
// Parameters
//   WAYS   associativity (power of two, 1..8)
//   SETS   number of sets (power of two, >= 2)
//   DATA_W word width
//   ADDR_W byte address width
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req, wr, addr,    core request; accepted on req && ready
//   wdata
//   ready             idle and able to accept
//   resp_valid, rdata one-cycle response pulse; rdata held until next pulse
//   mem_req, mem_wr,  backing-store request, held until mem_ack
//   mem_addr,
//   mem_wdata
//   mem_ack,          backing-store completion, read data valid with ack
//   mem_rdata
//   hit_cnt, miss_cnt saturating read hit/miss counters (CACHE_STATS_EN only)
//
// Build option
//   CACHE_STATS_EN    adds hit_cnt / miss_cnt outputs and counters

// One way: per-set valid/tag/data storage with a lookup port and a write port.
module cache_nway_way #(
    parameter int SETS   = 2,
    parameter int IDX_W  = 1,
    parameter int TAG_W  = 29,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  lk_idx,
    input  logic [TAG_W-1:0]  lk_tag,
    output logic              hit,
    output logic [DATA_W-1:0] data,
    input  logic              we,
    input  logic [IDX_W-1:0]  w_idx,
    input  logic [TAG_W-1:0]  w_tag,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_vld
);
    logic [SETS-1:0]             vld;
    logic [SETS-1:0][TAG_W-1:0]  tag_q;
    logic [SETS-1:0][DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst)
            vld <= '0;
        else if (we)
            vld[w_idx] <= 1'b1;
    end

    // Tag/data need no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[w_idx]  <= w_tag;
            data_q[w_idx] <= w_data;
        end
    end

    assign hit   = vld[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign data  = data_q[lk_idx];
    assign w_vld = vld[w_idx];
endmodule

module cache_nway_ctrl #(
    parameter int WAYS   = 4,
    parameter int SETS   = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
`ifdef CACHE_STATS_EN
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`else
    input  logic [DATA_W-1:0] mem_rdata
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, MISS, WRITE} state_t;
    state_t state;

    logic [IDX_W-1:0] req_idx, fill_idx, w_idx;
    logic [TAG_W-1:0] req_tag, fill_tag, w_tag;
    logic [DATA_W-1:0] w_data;

    assign req_idx  = addr[2 +: IDX_W];
    assign req_tag  = addr[ADDR_W-1 -: TAG_W];
    // The latched line address of the outstanding miss picks the fill set.
    assign fill_idx = mem_addr[2 +: IDX_W];
    assign fill_tag = mem_addr[ADDR_W-1 -: TAG_W];

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    logic [WAYS-1:0]             way_hit, way_we, way_vld;
    logic [WAYS-1:0][DATA_W-1:0] way_data;
    logic [SETS-1:0][WAY_W-1:0]  rr;
    logic [WAY_W-1:0]            victim;
    logic                        hit_any;
    logic [DATA_W-1:0]           hit_data;
    logic                        fill_now, wr_hit_now;

    assign fill_now   = (state == MISS) && mem_ack;
    assign wr_hit_now = (state == IDLE) && req && wr;

    // Shared write port: fill from memory in MISS, write-hit update in IDLE.
    assign w_idx  = (state == MISS) ? fill_idx  : req_idx;
    assign w_tag  = (state == MISS) ? fill_tag  : req_tag;
    assign w_data = (state == MISS) ? mem_rdata : wdata;

    genvar g;
    generate
        for (g = 0; g < WAYS; g++) begin : g_way
            assign way_we[g] = (fill_now && (victim == WAY_W'(g))) ||
                               (wr_hit_now && way_hit[g]);
            cache_nway_way #(
                .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
            ) u_way (
                .clk   (clk),
                .rst   (rst),
                .lk_idx(req_idx),
                .lk_tag(req_tag),
                .hit   (way_hit[g]),
                .data  (way_data[g]),
                .we    (way_we[g]),
                .w_idx (w_idx),
                .w_tag (w_tag),
                .w_data(w_data),
                .w_vld (way_vld[g])
            );
        end
    endgenerate

    // At most one way can match, so an OR-mux is enough.
    always_comb begin
        hit_any  = |way_hit;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++)
            if (way_hit[w]) hit_data = hit_data | way_data[w];
    end

    // Lowest invalid way in the fill set, else the set's round-robin pointer.
    always_comb begin
        logic found;
        found  = 1'b0;
        victim = rr[fill_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !way_vld[w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ready      <= 1'b1;
            resp_valid <= 1'b0;
            rdata      <= '0;
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rr         <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!wr && hit_any) begin
                            rdata      <= hit_data;
                            resp_valid <= 1'b1;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_wr   <= wr;
                            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                            ready    <= 1'b0;
                            if (wr) begin
                                mem_wdata <= wdata;
                                state     <= WRITE;
                            end else begin
                                state     <= MISS;
                            end
                        end
                    end
                end
                MISS: begin
                    if (mem_ack) begin
                        rdata      <= mem_rdata;
                        resp_valid <= 1'b1;
                        mem_req    <= 1'b0;
                        ready      <= 1'b1;
                        state      <= IDLE;
                        // Pointer only advances when a valid line is evicted.
                        if (&way_vld)
                            rr[fill_idx] <= (rr[fill_idx] == WAY_W'(WAYS - 1)) ?
                                            '0 : rr[fill_idx] + 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        resp_valid <= 1'b1;
                        mem_req    <= 1'b0;
                        mem_wr     <= 1'b0;
                        ready      <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == IDLE && req && !wr) begin
            if (hit_any && hit_cnt != '1)
                hit_cnt <= hit_cnt + 1'b1;
            if (!hit_any && miss_cnt != '1)
                miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Directed bench for cache_nway_ctrl at default parameters. A negedge-driven
// backing-store responder with programmable ack delay serves mem_req.
module tb_cache_nway_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, resp_valid, mem_req, mem_wr;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    cache_nway_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready), .resp_valid(resp_valid), .rdata(rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
`ifdef CACHE_STATS_EN
        .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`else
        .mem_rdata(mem_rdata)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ack_dly = 0;
    int cnt = 0;
    int n_req_cyc = 0;
    int last_lat = 0;
    logic [31:0] mem [0:63];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Backing store: acks after ack_dly cycles of mem_req, one-cycle ack pulse.
    always @(negedge clk) begin
        if (rst || mem_ack || !mem_req) begin
            mem_ack = 1'b0;
            cnt     = 0;
        end else begin
            n_req_cyc++;
            if (cnt >= ack_dly) begin
                chk("mem_addr_lsb", {30'b0, mem_addr[1:0]}, 32'h0);
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[7:2]];
                if (mem_wr) mem[mem_addr[7:2]] = mem_wdata;
            end else begin
                cnt++;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One core access, started and ended at a negedge.
    task automatic access(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp, input logic exp_hit);
        int n0, cyc;
        n0 = n_req_cyc;
        req = 1'b1; wr = w; addr = a; wdata = d;
        cyc = 0;
        while (!ready && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk);
        req = 1'b0; wr = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 50) begin @(negedge clk); cyc++; end
        last_lat = cyc;
        chk({tag, ".resp"}, 32'(resp_valid), 32'h1);
        chk({tag, ".ready"}, 32'(ready), 32'h1);
        if (!w) begin
            chk({tag, ".rdata"}, rdata, exp);
            chk({tag, ".hit"}, 32'(n_req_cyc == n0 && cyc == 1), 32'(exp_hit));
        end else begin
            chk({tag, ".memw"}, mem[a[7:2]], d);
        end
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(resp_valid), 32'h0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[4] = 32'hDEAD_BEEF;

        // Reset state and first miss/hit pair with a delayed ack.
        do_reset();
        chk("rst.ready", 32'(ready), 32'h1);
        chk("rst.resp_valid", 32'(resp_valid), 32'h0);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.mem_req", 32'(mem_req), 32'h0);
        chk("rst.mem_wr", 32'(mem_wr), 32'h0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        ack_dly = 2;
        access("a_rd10_miss", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        chk("a_miss_lat", 32'(last_lat), 32'd4);
        access("a_rd10_hit", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1);

        // Fill set 0 and exercise round-robin eviction.
        do_reset();
        ack_dly = 1;
        access("b_rd00", 1'b0, 32'h00, 32'h0, 32'h1000_0000, 1'b0);
        access("b_rd08", 1'b0, 32'h08, 32'h0, 32'h1000_0002, 1'b0);
        access("b_rd10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access("b_rd1b", 1'b0, 32'h1B, 32'h0, 32'h1000_0006, 1'b0);
        access("b_rd00_hit", 1'b0, 32'h00, 32'h0, 32'h1000_0000, 1'b1);
        access("b_rd20_evict", 1'b0, 32'h20, 32'h0, 32'h1000_0008, 1'b0);
        access("b_rd08_hit", 1'b0, 32'h08, 32'h0, 32'h1000_0002, 1'b1);
        access("b_rd00_gone", 1'b0, 32'h00, 32'h0, 32'h1000_0000, 1'b0);
        access("b_rd10_hit", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1);
        access("b_rd08_gone", 1'b0, 32'h08, 32'h0, 32'h1000_0002, 1'b0);

        // Zero-wait ack, write-through with update on hit, no write allocate.
        do_reset();
        ack_dly = 0;
        access("c_rd08", 1'b0, 32'h08, 32'h0, 32'h1000_0002, 1'b0);
        chk("c_zero_wait_lat", 32'(last_lat), 32'd2);
        access("c_wr08", 1'b1, 32'h08, 32'h1234_5678, 32'h0, 1'b0);
        access("c_rd08_hit", 1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b1);
        access("c_wr40", 1'b1, 32'h40, 32'hCAFE_0000, 32'h0, 1'b0);
        access("c_rd40_miss", 1'b0, 32'h40, 32'h0, 32'hCAFE_0000, 1'b0);
        access("c_rd08_still", 1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b1);

        // Reset in the middle of a miss.
        ack_dly = 10;
        req = 1'b1; wr = 1'b0; addr = 32'h18;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("d_req_hi", 32'(mem_req), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("d_req_dropped", 32'(mem_req), 32'h0);
        chk("d_ready", 32'(ready), 32'h1);
        seen = 0;
        repeat (12) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        chk("d_no_resp", 32'(seen), 32'h0);
        ack_dly = 1;
        access("d_rd08_invalid", 1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b0);

        // Counter traffic: 3 hits, 2 misses, one uncounted write.
        access("e_wr08", 1'b1, 32'h08, 32'h0BAD_F00D, 32'h0, 1'b0);
        access("e_rd08_h1", 1'b0, 32'h08, 32'h0, 32'h0BAD_F00D, 1'b1);
        access("e_rd08_h2", 1'b0, 32'h08, 32'h0, 32'h0BAD_F00D, 1'b1);
        access("e_rd08_h3", 1'b0, 32'h08, 32'h0, 32'h0BAD_F00D, 1'b1);
        access("e_rd10_miss", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
`ifdef CACHE_STATS_EN
        chk("e_hit_cnt", hit_cnt, 32'd3);
        chk("e_miss_cnt", miss_cnt, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
